// File: rtl/piece_dispenser.sv
// piece_dispenser: keeps a 7-bag randomized preview queue of tetromino
// types and issues the active falling piece on spawn or swap requests.
module piece_dispenser #(
  parameter int          QUEUE_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_spawn_req,
  input  logic                     i_swap_req,
  input  logic                     i_swap_empty,
  input  logic [2:0]               i_hold_type,
  output logic                     o_piece_valid,
  output logic [2:0]               o_piece_type,
  output logic [3*QUEUE_DEPTH-1:0] o_preview,
  output logic                     o_busy
);

  localparam int             CW      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic {S_FILL, S_IDLE} state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [6:0]    r_bag;
  logic [CW-1:0] r_count;
  logic          r_pending;
  logic          r_piece_valid;
  logic [2:0]    r_piece_type;
  logic          r_busy;
  logic [2:0]    r_queue [QUEUE_DEPTH];

  logic          w_lfsr_fb;
  logic          w_pop_req;
  logic          w_serve_hold;
  logic          w_pop;
  logic          w_set_pend;
  logic          w_push;
  logic [2:0]    w_draw;
  logic [6:0]    w_bag_clr;
  logic [CW-1:0] w_slot;
  logic [CW-1:0] w_count_nxt;
  logic [2:0]    w_queue_nxt [QUEUE_DEPTH];

  // Pick the bag entry for candidate cand: cand itself if still available,
  // otherwise the next available type scanning upward modulo 7.
  function automatic logic [2:0] f_draw(input logic [2:0] cand, input logic [6:0] bag);
    logic [2:0] start;
    logic [2:0] pick;
    logic [2:0] idx3;
    logic       found;
    start = (cand == 3'd7) ? 3'd0 : cand;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      idx3 = 3'((int'(start) + k) % 7);
      if (!found && bag[idx3]) begin
        pick  = idx3;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Fibonacci LFSR taps 16,14,13,11 (right-shifting form).
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Request arbitration, pending handling and next queue contents.
  always_comb begin
    // swap wins over spawn; a swap only needs the queue when hold is empty
    w_pop_req    = i_swap_req ? i_swap_empty : i_spawn_req;
    w_serve_hold = i_swap_req & ~i_swap_empty & ~r_pending;
    w_pop        = (r_pending | w_pop_req) & (r_count != '0) &
                   ~(w_serve_hold);
    w_set_pend   = w_pop_req & ~r_pending & (r_count == '0);
    w_push       = (r_state == S_FILL);
    w_draw       = f_draw(r_lfsr[2:0], r_bag);
    w_bag_clr    = r_bag & ~(7'd1 << w_draw);
    // when popping and pushing together the new entry goes behind the shift
    w_slot       = w_pop ? (r_count - CW'(1)) : r_count;
    w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_queue_nxt[i] = r_queue[i];
    end
    if (w_pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        w_queue_nxt[i] = r_queue[i + 1];
      end
      w_queue_nxt[QUEUE_DEPTH - 1] = 3'd0;
    end
    if (w_push) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (CW'(i) == w_slot) begin
          w_queue_nxt[i] = w_draw;
        end
      end
    end
  end

  // FSM, queue, bag, LFSR and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_FILL;
      r_lfsr        <= LFSR_SEED;
      r_bag         <= 7'h7F;
      r_count       <= '0;
      r_pending     <= 1'b0;
      r_piece_valid <= 1'b0;
      r_piece_type  <= 3'd0;
      r_busy        <= 1'b1;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_queue[i] <= 3'd0;
      end
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      if (w_push) begin
        r_bag <= (w_bag_clr == 7'd0) ? 7'h7F : w_bag_clr;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_queue[i] <= w_queue_nxt[i];
      end
      r_count <= w_count_nxt;
      r_state <= (w_count_nxt == DEPTH_C) ? S_IDLE : S_FILL;
      r_busy  <= (w_count_nxt != DEPTH_C);
      if (w_set_pend) begin
        r_pending <= 1'b1;
      end else if (w_pop) begin
        r_pending <= 1'b0;
      end
      r_piece_valid <= w_serve_hold | w_pop;
      if (w_serve_hold) begin
        r_piece_type <= i_hold_type;
      end else if (w_pop) begin
        r_piece_type <= r_queue[0];
      end
    end
  end

  for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_preview
    assign o_preview[3*g +: 3] = r_queue[g];
  end

  assign o_piece_valid = r_piece_valid;
  assign o_piece_type  = r_piece_type;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_piece_dispenser.sv
// Directed self-checking bench for piece_dispenser (QUEUE_DEPTH=3).
module tb_piece_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       spawn_req;
  logic       swap_req;
  logic       swap_empty;
  logic [2:0] hold_type;
  logic       piece_valid;
  logic [2:0] piece_type;
  logic [8:0] preview;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] prevp;
  logic [2:0] head;
  logic [7:0] mask;
  logic [2:0] hand [3];

  piece_dispenser #(.QUEUE_DEPTH(3), .LFSR_SEED(16'hACE1)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_spawn_req  (spawn_req),
    .i_swap_req   (swap_req),
    .i_swap_empty (swap_empty),
    .i_hold_type  (hold_type),
    .o_piece_valid(piece_valid),
    .o_piece_type (piece_type),
    .o_preview    (preview),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    hand[0] = 3'd1; hand[1] = 3'd0; hand[2] = 3'd2;
    rst = 1'b1; spawn_req = 1'b0; swap_req = 1'b0; swap_empty = 1'b0; hold_type = 3'd0;
    repeat (2) tick();
    chk("rst_type", piece_type, 0);
    chk("rst_valid", piece_valid, 0);
    chk("rst_preview", preview, 0);
    chk("rst_busy", busy, 1);

    // reset fill: seed 16'hACE1 draws 1, 0, 2
    rst = 1'b0;
    chk("fill_busy0", busy, 1);
    tick(); chk("fill_busy1", busy, 1); chk("fill_valid1", piece_valid, 0);
    tick(); chk("fill_busy2", busy, 1); chk("fill_valid2", piece_valid, 0);
    tick(); chk("fill_busy3", busy, 0); chk("fill_valid3", piece_valid, 0);
    chk("fill_preview", preview, 9'h081);

    // bag fairness over 14 spaced pops
    mask = 8'h00;
    for (int n = 0; n < 14; n++) begin
      head = preview[2:0];
      spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
      chk("bag_valid", piece_valid, 1);
      chk("bag_head", piece_type, head);
      if (n < 3) chk("bag_hand", piece_type, hand[n]);
      mask = mask | (8'd1 << piece_type);
      if (n == 6 || n == 13) begin
        chk("bag_mask", mask, 8'h7F);
        mask = 8'h00;
      end
      tick();
      chk("bag_pulse", piece_valid, 0);
      tick(); tick();
    end
    chk("bag_full", busy, 0);

    // swap with held piece
    prevp = preview;
    hold_type = 3'd5; swap_empty = 1'b0; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("hold_valid", piece_valid, 1);
    chk("hold_type", piece_type, 5);
    chk("hold_preview", preview, prevp);
    chk("hold_busy", busy, 0);
    tick();
    chk("hold_pulse", piece_valid, 0);

    // swap with empty hold pops the queue
    prevp = preview;
    swap_empty = 1'b1; swap_req = 1'b1;
    tick();
    swap_req = 1'b0; swap_empty = 1'b0;
    chk("swe_valid", piece_valid, 1);
    chk("swe_type", piece_type, prevp[2:0]);
    chk("swe_preview", preview, {3'd0, prevp[8:3]});
    chk("swe_busy", busy, 1);
    mask = mask | (8'd1 << piece_type);
    tick();
    chk("swe_pulse", piece_valid, 0);
    chk("swe_refill", busy, 0);
    chk("swe_keep", preview[5:0], prevp[8:3]);

    // four back-to-back spawns
    prevp = preview;
    spawn_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      head = preview[2:0];
      tick();
      if (k == 3) spawn_req = 1'b0;
      chk("b2b_valid", piece_valid, 1);
      chk("b2b_head", piece_type, head);
      if (k == 0) chk("b2b_e0", piece_type, prevp[2:0]);
      if (k == 1) chk("b2b_e1", piece_type, prevp[5:3]);
      if (k == 2) chk("b2b_e2", piece_type, prevp[8:6]);
      mask = mask | (8'd1 << piece_type);
    end
    tick();
    chk("b2b_end", piece_valid, 0);
    tick(); tick();
    for (int n = 0; n < 2; n++) begin
      head = preview[2:0];
      spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
      chk("bag3_head", piece_type, head);
      mask = mask | (8'd1 << piece_type);
      tick(); tick(); tick();
    end
    chk("bag3_mask", mask, 8'h7F);
    chk("bag3_full", busy, 0);

    // spawn and held swap together: only the swap is served
    prevp = preview;
    spawn_req = 1'b1; swap_req = 1'b1; swap_empty = 1'b0; hold_type = 3'd2;
    tick();
    spawn_req = 1'b0; swap_req = 1'b0;
    chk("col_valid", piece_valid, 1);
    chk("col_type", piece_type, 2);
    chk("col_preview", preview, prevp);
    tick();
    chk("col_pulse", piece_valid, 0);
    chk("col_preview2", preview, prevp);

    // asynchronous reset mid-fill discards the in-flight piece_valid
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_type", piece_type, 0);
    chk("mid_valid", piece_valid, 0);
    chk("mid_preview", preview, 0);
    chk("mid_busyr", busy, 1);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("re_preview", preview, 9'h081);
    chk("re_busy", busy, 0);

    // request while empty pends; second request during pending is dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    spawn_req = 1'b1;
    chk("pend_empty", preview, 0);
    tick();
    chk("pend_v1", piece_valid, 0);
    chk("pend_p1", preview, 9'h001);
    tick();
    spawn_req = 1'b0;
    chk("pend_v2", piece_valid, 1);
    chk("pend_t2", piece_type, 1);
    tick();
    chk("pend_v3", piece_valid, 0);
    chk("pend_p3", preview[5:0], 6'h10);
    tick();
    chk("pend_v4", piece_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
